team_05_wb_master_ctrl: RTL and testbench

TEAM_05_WB_MASTER_CTRL -- requirements
Module: team_05_wb_master_ctrl

---
 rtl/team_05_wb_master_ctrl_pkg.sv | 15 +
 rtl/team_05_wb_master_ctrl_if.sv | 24 ++
 rtl/team_05_wb_master_ctrl_timeout.sv | 40 ++++
 rtl/team_05_wb_master_ctrl.sv | 146 ++++++++++++++
 tb/tb_team_05_wb_master_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/team_05_wb_master_ctrl_pkg.sv
// rtl/team_05_wb_master_ctrl_pkg.sv - shared types and widths for the Wishbone master controller
package team_05_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
  localparam int TO_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/team_05_wb_master_ctrl_if.sv
// rtl/team_05_wb_master_ctrl_if.sv - Wishbone classic bus bundle with master/slave views
interface team_05_wb_master_ctrl_if;
  import team_05_pkg::*;

  logic [WB_ADR_W-1:0] ADR_O;
  logic [WB_DAT_W-1:0] DAT_O;
  logic [WB_SEL_W-1:0] SEL_O;
  logic                WE_O;
  logic                STB_O;
  logic                CYC_O;
  logic [WB_DAT_W-1:0] DAT_I;
  logic                ACK_I;

  modport master (
    output ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
    input  DAT_I, ACK_I
  );

  modport slave (
    input  ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
    output DAT_I, ACK_I
  );

endinterface

// File: rtl/team_05_wb_master_ctrl_timeout.sv
// rtl/team_05_wb_master_ctrl_timeout.sv - BUS-phase watchdog counter, built only with TEAM_05_WB_TIMEOUT_EN
`ifdef TEAM_05_WB_TIMEOUT_EN
module team_05_wb_timeout
  import team_05_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [TO_CNT_W-1:0] CNT_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TO_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + TO_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count k-1 during the k-th BUS cycle, so expiry lands on cycle TIMEOUT_CYCLES.
  assign expired_o = (cnt_q == CNT_LAST);

endmodule
`endif

// File: rtl/team_05_wb_master_ctrl.sv
// rtl/team_05_wb_master_ctrl.sv - single-transfer Wishbone classic master; TEAM_05_WB_TIMEOUT_EN adds BUS abort
module team_05_wb_master_ctrl
  import team_05_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     req_i,
  input  logic                     req_we_i,
  input  logic [WB_ADR_W-1:0]      req_adr_i,
  input  logic [WB_DAT_W-1:0]      req_dat_i,
  input  logic [WB_SEL_W-1:0]      req_sel_i,
  output logic                     req_ready_o,
  output logic                     rsp_valid_o,
  output logic [WB_DAT_W-1:0]      rsp_dat_o,
  output logic                     rsp_err_o,
  team_05_wb_master_ctrl_if.master wb
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("team_05_wb_master_ctrl: TIMEOUT_CYCLES must be within 2..65535");
  end

  state_e              state_q, state_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [WB_ADR_W-1:0] adr_q, adr_d;
  logic [WB_DAT_W-1:0] dat_q, dat_d;
  logic [WB_SEL_W-1:0] sel_q, sel_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WB_DAT_W-1:0] rsp_dat_q, rsp_dat_d;
  logic                accept;
  logic                bus_done;
  logic                unused_adr_lsb;

  assign unused_adr_lsb = ^req_adr_i[1:0];
  assign req_ready_o    = (state_q == ST_IDLE) && !wb_rst_i;
  assign accept         = req_i && req_ready_o;

`ifdef TEAM_05_WB_TIMEOUT_EN
  logic to_expired;
  logic rsp_err_q, rsp_err_d;

  team_05_wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .clear_i  (state_q != ST_BUS),
    .enable_i ((state_q == ST_BUS) && !wb.ACK_I),
    .expired_o(to_expired)
  );

  assign bus_done  = wb.ACK_I || to_expired;
  assign rsp_err_o = rsp_err_q;
`else
  assign bus_done  = wb.ACK_I;
  assign rsp_err_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = rsp_dat_q;
`ifdef TEAM_05_WB_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_BUS;
          cyc_d   = 1'b1;
          we_d    = req_we_i;
          adr_d   = {req_adr_i[WB_ADR_W-1:2], 2'b00};
          dat_d   = req_dat_i;
          sel_d   = req_sel_i;
        end
      end
      ST_BUS: begin
        if (bus_done) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          dat_d       = '0;
          sel_d       = '0;
          rsp_valid_d = 1'b1;
          // An ACK on the expiry cycle still completes the transfer normally.
          rsp_dat_d   = (wb.ACK_I && !we_q) ? wb.DAT_I : '0;
`ifdef TEAM_05_WB_TIMEOUT_EN
          rsp_err_d   = !wb.ACK_I;
`endif
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
`ifdef TEAM_05_WB_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
`ifdef TEAM_05_WB_TIMEOUT_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign wb.CYC_O    = cyc_q;
  assign wb.STB_O    = cyc_q;
  assign wb.WE_O     = we_q;
  assign wb.ADR_O    = adr_q;
  assign wb.DAT_O    = dat_q;
  assign wb.SEL_O    = sel_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;

endmodule

// File: tb/tb_team_05_wb_master_ctrl.sv
// tb/tb_team_05_wb_master_ctrl.sv - scoreboard bench for team_05_wb_master_ctrl
module tb_team_05_wb_master_ctrl;

  localparam int TO = 8;
`ifdef TEAM_05_WB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        req_i, req_we_i;
  logic [31:0] req_adr_i, req_dat_i;
  logic [3:0]  req_sel_i;
  logic        req_ready_o, rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_dat_o;

  team_05_wb_master_ctrl_if wb ();

  team_05_wb_master_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .req_i      (req_i),
    .req_we_i   (req_we_i),
    .req_adr_i  (req_adr_i),
    .req_dat_i  (req_dat_i),
    .req_sel_i  (req_sel_i),
    .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o),
    .rsp_dat_o  (rsp_dat_o),
    .rsp_err_o  (rsp_err_o),
    .wb         (wb)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int   checks = 0;
  int   errors = 0;
  int   cyc_n = 0;
  rsp_t exp_q[$];
  logic rsp_due = 1'b0;
  logic exp_cyc = 1'b0;
  logic ack_noise = 1'b0;
  logic ack_all = 1'b0;
  logic        cur_we = 1'b0;
  logic [31:0] cur_adr = 32'h0, cur_dat = 32'h0, cur_rdata = 32'h0;
  logic [3:0]  cur_sel = 4'h0;
  int          cur_delay = 0;

  always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // Called right after the request lines are driven and seen ready: the next edge accepts.
  task automatic note_accept(input int delay, input logic [31:0] rdata);
    rsp_t r;
    cur_we    = req_we_i;
    cur_adr   = req_adr_i & 32'hFFFF_FFFC;
    cur_dat   = req_dat_i;
    cur_sel   = req_sel_i;
    cur_rdata = rdata;
    cur_delay = delay;
    r.err = TO_EN && (delay >= TO);
    r.dat = (r.err || req_we_i) ? 32'h0 : rdata;
    exp_q.push_back(r);
    exp_cyc = 1'b1;
  endtask

  task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic [31:0] rdata, input int delay);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge wb_clk_i); #1;
      if (req_ready_o) begin
        req_i = 1'b1; req_we_i = we; req_adr_i = adr; req_dat_i = dat; req_sel_i = sel;
        note_accept(delay, rdata);
        ok = 1'b1;
      end
    end
    chk1("send_ready_wait", ok, 1'b1);
    @(negedge wb_clk_i); #1;
    req_i = 1'b0; req_we_i = ~we; req_adr_i = $urandom; req_dat_i = $urandom; req_sel_i = ~sel;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wb.CYC_O) && n < max) begin
      @(negedge wb_clk_i); #1;
      n++;
    end
    chk1("drain_within_budget", n < max, 1'b1);
  endtask

  // Wishbone slave: acks after the planned number of wait cycles, random data otherwise.
  initial begin
    int bus_cyc;
    bus_cyc = 0;
    wb.ACK_I = 1'b0;
    wb.DAT_I = 32'h0;
    forever begin
      @(negedge wb_clk_i); #1;
      wb.DAT_I = $urandom;
      if (wb.CYC_O) begin
        bus_cyc++;
        wb.ACK_I = (bus_cyc == cur_delay + 1);
        if (wb.ACK_I) begin
          wb.DAT_I = cur_rdata;
          rsp_due  = 1'b1;
        end else if (TO_EN && bus_cyc == TO) begin
          rsp_due = 1'b1;
        end
      end else begin
        bus_cyc  = 0;
        wb.ACK_I = ack_all ? 1'b1 : (ack_noise ? 1'($urandom_range(0, 1)) : 1'b0);
      end
    end
  end

  // Monitor: bus fields, response timing and scoreboard comparison.
  initial begin
    rsp_t        r;
    logic [31:0] last_dat;
    logic        last_err;
    last_dat = 32'h0;
    last_err = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_i) begin
        chk1("rst_cyc", wb.CYC_O, 1'b0);
        chk1("rst_stb", wb.STB_O, 1'b0);
        chk1("rst_we", wb.WE_O, 1'b0);
        chk32("rst_adr", wb.ADR_O, 32'h0);
        chk32("rst_dat_o", wb.DAT_O, 32'h0);
        chk32("rst_sel", 32'(wb.SEL_O), 32'h0);
        chk1("rst_rsp_valid", rsp_valid_o, 1'b0);
        chk32("rst_rsp_dat", rsp_dat_o, 32'h0);
        chk1("rst_rsp_err", rsp_err_o, 1'b0);
        chk1("rst_ready_low", req_ready_o, 1'b0);
        last_dat = 32'h0;
        last_err = 1'b0;
        rsp_due  = 1'b0;
        exp_cyc  = 1'b0;
      end else begin
        if (exp_cyc) begin
          chk1("cyc_after_accept", wb.CYC_O, 1'b1);
          exp_cyc = 1'b0;
        end
        if (wb.CYC_O) begin
          chk1("bus_stb", wb.STB_O, 1'b1);
          chk32("bus_adr", wb.ADR_O, cur_adr);
          chk32("bus_dat", wb.DAT_O, cur_dat);
          chk32("bus_sel", 32'(wb.SEL_O), 32'(cur_sel));
          chk1("bus_we", wb.WE_O, cur_we);
        end else begin
          chk1("idle_stb", wb.STB_O, 1'b0);
          chk1("idle_we", wb.WE_O, 1'b0);
          chk32("idle_sel", 32'(wb.SEL_O), 32'h0);
          chk32("idle_dat", wb.DAT_O, 32'h0);
        end
        chk1("rsp_valid_timing", rsp_valid_o, rsp_due);
        if (rsp_due) begin
          rsp_due = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_scoreboard_empty actual=response required=none t=%0t", $time);
          end else begin
            r = exp_q.pop_front();
            chk32("rsp_dat", rsp_dat_o, r.dat);
            chk1("rsp_err", rsp_err_o, r.err);
            last_dat = r.dat;
            last_err = r.err;
          end
        end else begin
          chk32("rsp_dat_hold", rsp_dat_o, last_dat);
          chk1("rsp_err_hold", rsp_err_o, last_err);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc[$];
    wb_rst_i = 1'b1;
    req_i = 1'b0; req_we_i = 1'b0; req_adr_i = 32'h0; req_dat_i = 32'h0; req_sel_i = 4'h0;
    repeat (3) @(negedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    @(negedge wb_clk_i); #1;
    chk1("ready_after_reset", req_ready_o, 1'b1);

    // Read, ACK in second BUS cycle.
    send(1'b0, 32'h3000_0004, 32'h1111_2222, 4'hF, 32'hDEAD_BEEF, 1);
    wait_idle(30);
    // Unaligned write, ACK in first BUS cycle.
    send(1'b1, 32'h3000_0013, 32'h1234_5678, 4'b0011, 32'hFFFF_FFFF, 0);
    wait_idle(30);

    // Continuous request with ACK_I held high everywhere.
    ack_all = 1'b1;
    for (int i = 0; i < 40 && acc.size() < 6; i++) begin
      @(negedge wb_clk_i); #1;
      req_i = 1'b1; req_we_i = 1'($urandom); req_adr_i = $urandom;
      req_dat_i = $urandom; req_sel_i = 4'($urandom);
      if (req_ready_o) begin
        note_accept(0, $urandom);
        acc.push_back(cyc_n);
      end
    end
    @(negedge wb_clk_i); #1;
    req_i = 1'b0;
    wait_idle(30);
    ack_all = 1'b0;
    chk32("b2b_accept_count", 32'(acc.size()), 32'd6);
    for (int i = 1; i < acc.size(); i++) chk32("b2b_accept_spacing", 32'(acc[i] - acc[i-1]), 32'd3);

    // Randomized traffic with noisy ACK_I outside BUS.
    ack_noise = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge wb_clk_i); #1;
      req_i = 1'($urandom_range(0, 1)); req_we_i = 1'($urandom); req_adr_i = $urandom;
      req_dat_i = $urandom; req_sel_i = 4'($urandom);
      if (req_i && req_ready_o) note_accept($urandom_range(0, 3), $urandom);
    end
    @(negedge wb_clk_i); #1;
    req_i = 1'b0;
    wait_idle(30);
    ack_noise = 1'b0;

`ifdef TEAM_05_WB_TIMEOUT_EN
    send(1'b0, 32'h4000_0000, 32'h0, 4'hF, 32'hABCD_0123, 1000);
    wait_idle(40);
    send(1'b0, 32'h4000_0008, 32'h0, 4'hF, 32'h0BAD_F00D, TO - 1);
    wait_idle(40);
    send(1'b1, 32'h4000_000C, 32'h5555_AAAA, 4'h5, 32'h0, 1000);
    wait_idle(40);
`endif

    // Reset during the third BUS cycle of a stalled read.
    send(1'b0, 32'h3000_0100, 32'h0, 4'hF, 32'hCAFE_0000, 1000);
    @(negedge wb_clk_i); #1;
    @(negedge wb_clk_i); #1;
    wb_rst_i = 1'b1;
    void'(exp_q.pop_back());
    @(negedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i); #1;
    chk1("ready_after_bus_reset", req_ready_o, 1'b1);
    chk1("cyc_low_after_bus_reset", wb.CYC_O, 1'b0);

    send(1'b0, 32'h3000_0200, 32'h0, 4'hF, 32'h7654_3210, 2);
    wait_idle(30);
    repeat (3) @(negedge wb_clk_i);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
